sha256_digest_serializer: RTL
=============================

// Module: sha256_digest_serializer
// PURPOSE
//  Downstream consumer of the SHA-256 core's digest channel (v/digest/yumi).
//  Accepts one 256-bit digest per transaction and streams it out as
//  DIGEST_W/WORD_W narrow words over a valid/ready link toward the FSB return path.
//  Frees the core as soon as the digest is captured, so the core can start the next hash
//  while the previous digest is still draining.
// PARAMETERS
//  DIGEST_W  256  digest width; must be an integer multiple of WORD_W
//  WORD_W    32   output word width; NUM_WORDS = DIGEST_W/WORD_W (default 8)
// PORTS
//  clk_i        in   1         single clock; all state updates on posedge
//  reset_n_i    in   1         asynchronous, active-low reset
//  v_i          in   1         digest valid from core (core v_o)
//  digest_i     in   DIGEST_W  digest from core; H0 occupies bits [31:0]
//  yumi_o       out  1         digest consumed this cycle (drives core yumi_i)
//  v_o          out  1         data_o valid
//  ready_i      in   1         downstream accepts data_o this cycle
//  data_o       out  WORD_W    current output word
//  last_o       out  1         data_o is the final word of the digest
// BEHAVIOUR
//  - Reset (async assert, sync release): state=eIdle, word index=0, shift reg=0;
//    yumi_o=0, v_o=0, data_o=0, last_o=0.
//  - States: eIdle (empty), eSend (holding a digest, words pending).
//  - eIdle: yumi_o = v_i (combinational). On v_i: capture digest_i, idx<=0, go eSend.
//    v_o=0 in eIdle; first word appears on v_o/data_o the cycle after capture (latency 1).
//  - eSend: v_o=1, data_o = captured[idx*WORD_W +: WORD_W]; word 0 (H0) first.
//    last_o = (idx == NUM_WORDS-1). yumi_o=0 except on the last-word handshake below.
//  - Handshake: transfer iff v_o & ready_i. idx increments only on transfer; data_o and
//    v_o held stable while ready_i=0 (no word dropped or duplicated under backpressure).
//  - Last-word transfer: if v_i=1 same cycle -> yumi_o=1, capture new digest, idx<=0,
//    stay eSend (back-to-back, no bubble). If v_i=0 -> go eIdle, idx<=0.
//  - Index is $clog2(NUM_WORDS) bits; never wraps except via the last-word rule.
//  - v_i while in eSend (not on last transfer) is ignored: yumi_o=0, core holds digest.
//  - ready_i while v_o=0 has no effect.
//  - Reset asserted mid-stream: remaining words discarded, outputs return to reset
//    values immediately; no partial digest resumes after release.
//  - yumi_o never asserts without v_i; at most one digest captured per cycle.
// CONFIGURATION
//  SHA256_SER_BSWAP_EN defined: each output word is byte-reversed before data_o
//    (little-endian 32-bit words on the link); word order and last_o unchanged.
//  Not defined: data_o is the captured slice unmodified. Only meaningful with WORD_W=32;
//    elaboration error if defined with any other WORD_W.
// TESTING
//  Let D = words k=0..7 equal 32'hk*0x11111111 (word0=32'h00000000 .. word7=32'h77777777).
//  1 Single digest, ready_i=1: v_i=1 one cycle with D -> yumi_o=1 that cycle; next 8 cycles
//    data_o=00000000,11111111..77777777, last_o only with 77777777; then v_o=0.
//  2 Backpressure: D, ready_i toggling 1,0,0,1,... -> data_o/v_o stable on ready_i=0 cycles;
//    exactly 8 transfers in order, no repeats.
//  3 Back-to-back: D then D' (words 32'hA0000000+k) held valid -> yumi_o=1 on the
//    77777777 transfer; A0000000 on the very next cycle, 16 transfers with no gap.
//  4 v_i=1 during word 3 of D -> yumi_o=0 until last-word transfer; D' not lost or corrupted.
//  5 reset_n_i low after 3 words -> v_o=0,last_o=0,yumi_o=0 same cycle; after release
//    v_o stays 0 until a new v_i.
//  6 SHA256_SER_BSWAP_EN, word0=32'h01234567 -> first data_o=32'h67452301.

Source files
------------

// File: rtl/sha256_digest_serializer_if.sv
// Digest-in / word-out link bundle for sha256_digest_serializer.
// slave = serializer side, master = core + downstream side.
interface sha256_digest_serializer_if #(
  parameter int DIGEST_W = 256,
  parameter int WORD_W   = 32
);
  logic                v_i;
  logic [DIGEST_W-1:0] digest_i;
  logic                yumi_o;
  logic                v_o;
  logic                ready_i;
  logic [WORD_W-1:0]   data_o;
  logic                last_o;

  modport slave (
    input  v_i, digest_i, ready_i,
    output yumi_o, v_o, data_o, last_o
  );

  modport master (
    output v_i, digest_i, ready_i,
    input  yumi_o, v_o, data_o, last_o
  );
endinterface

// File: rtl/sha256_digest_serializer.sv
// Captures one SHA-256 digest and streams it out H0-first as WORD_W words.
// Optional macro SHA256_SER_BSWAP_EN byte-reverses each output word (WORD_W must be 32).
module sha256_digest_serializer #(
  parameter int DIGEST_W = 256,
  parameter int WORD_W   = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  sha256_digest_serializer_if.slave   link
);
  localparam int NUM_WORDS = DIGEST_W / WORD_W;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    eIdle,
    eSend
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DIGEST_W-1:0] shift_q, shift_d;

  logic                yumi;
  logic                vOut;
  logic                isLast;
  logic [WORD_W-1:0]   curWord;
  logic [WORD_W-1:0]   outWord;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= eIdle;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign curWord = shift_q[idx_q*WORD_W +: WORD_W];
  assign isLast  = (idx_q == LAST_IDX);

  // The last-word handshake doubles as the capture slot for the next digest.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    yumi    = 1'b0;
    vOut    = 1'b0;
    unique case (state_q)
      eIdle: begin
        yumi = link.v_i;
        if (link.v_i) begin
          shift_d = link.digest_i;
          idx_d   = '0;
          state_d = eSend;
        end
      end
      eSend: begin
        vOut = 1'b1;
        if (link.ready_i) begin
          if (isLast) begin
            idx_d = '0;
            if (link.v_i) begin
              yumi    = 1'b1;
              shift_d = link.digest_i;
            end else begin
              state_d = eIdle;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = eIdle;
        idx_d   = '0;
      end
    endcase
  end

`ifdef SHA256_SER_BSWAP_EN
  if (WORD_W != 32) begin : gBadWordWidth
    $error("SHA256_SER_BSWAP_EN requires WORD_W == 32");
  end

  always_comb begin
    outWord = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      outWord[b*8 +: 8] = curWord[(WORD_W/8 - 1 - b)*8 +: 8];
    end
  end
`else
  assign outWord = curWord;
`endif

  // Reset gating keeps yumi_o low while the core may still be presenting v_i.
  assign link.yumi_o = yumi & reset_n_i;
  assign link.v_o    = vOut;
  assign link.last_o = vOut & isLast;
  assign link.data_o = vOut ? outWord : '0;

endmodule
